// File: rtl/hzz_master_if_if.sv
// Bundle of DMA-side command/data signals and HZZ wire signals for the HZZ link initiator.
`timescale 1ns/1ps

// Handshakes: a transfer happens on a rising clk edge where both valid and ready are high;
// valid may not depend on ready. rdata_valid and hzzm_miso_valid are strobes with no backpressure.
interface hzz_master_if_if #(
    parameter int W = 64
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [53:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic         wdata_valid;
    logic         wdata_ready;
    logic [W-1:0] wdata;
    logic         rdata_valid;
    logic [W-1:0] rdata;
    logic         cmd_done;
    logic         cmd_err;
    logic [W-1:0] hzzm_mosi;
    logic         hzzm_mosi_valid;
    logic         hzzm_mosi_oe;
    logic         hzzm_miso_ie;
    logic [W-1:0] hzzm_miso;
    logic         hzzm_miso_valid;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
               hzzm_miso, hzzm_miso_valid,
        output cmd_ready, wdata_ready, rdata_valid, rdata, cmd_done, cmd_err,
               hzzm_mosi, hzzm_mosi_valid, hzzm_mosi_oe, hzzm_miso_ie
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata,
               hzzm_miso, hzzm_miso_valid,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, cmd_done, cmd_err,
               hzzm_mosi, hzzm_mosi_valid, hzzm_mosi_oe, hzzm_miso_ie
    );
endinterface

// File: rtl/hzz_master_if.sv
// HZZ link initiator: turns single-burst DMA commands into a header plus data beats and
// collects read beats or the write response, reporting completion with cmd_done/cmd_err.
`timescale 1ns/1ps

module hzz_master_if #(
    parameter int HZZ_T2D_WIDTH  = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    hzz_master_if_if.master       bus,
    output logic [2:0]            dbg_state_o
);
    localparam int W  = HZZ_T2D_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_DATA = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [W-1:0]  mosi_q, mosi_d;
    logic          mosi_valid_q, mosi_valid_d;
    logic          oe_q, oe_d;
    logic          ie_q, ie_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          cmd_legal;
    logic [W-1:0]  header;

    assign cmd_legal = (bus.cmd_addr[1:0] == 2'b00) && (bus.cmd_len[1:0] == 2'b11);

    always_comb begin
        header           = '0;
        header[W-1]      = bus.cmd_write;
        header[W-2]      = ~bus.cmd_write;
        header[W-3 -: 8] = bus.cmd_len;
        header[53:0]     = bus.cmd_addr;
    end

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        beat_cnt_d    = beat_cnt_q;
        tmo_d         = tmo_q;
        mosi_d        = mosi_q;
        mosi_valid_d  = 1'b0;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_legal) begin
                        write_d      = bus.cmd_write;
                        beat_cnt_d   = bus.cmd_len;
                        mosi_d       = header;
                        mosi_valid_d = 1'b1;
                        state_d      = S_HDR;
                    end else begin
                        // Illegal command is swallowed; only the error completion is reported.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_HDR: begin
                tmo_d   = '0;
                state_d = write_q ? S_WR_DATA : S_RD_DATA;
            end
            S_WR_DATA: begin
                if (bus.wdata_valid) begin
                    mosi_d       = bus.wdata;
                    mosi_valid_d = 1'b1;
                    if (beat_cnt_q == 8'd0) begin
                        tmo_d   = '0;
                        state_d = S_WR_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            S_WR_RESP: begin
                if (bus.hzzm_miso_valid) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RD_DATA: begin
                if (bus.hzzm_miso_valid) begin
                    rdata_d       = bus.hzzm_miso;
                    rdata_valid_d = 1'b1;
                    tmo_d         = '0;
                    if (beat_cnt_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pad enables follow the next state so they switch on the same edge as the FSM.
        oe_d = (state_d != S_RD_DATA);
        ie_d = (state_d == S_WR_RESP) || (state_d == S_RD_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            beat_cnt_q    <= '0;
            tmo_q         <= '0;
            mosi_q        <= '0;
            mosi_valid_q  <= 1'b0;
            oe_q          <= 1'b1;
            ie_q          <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            beat_cnt_q    <= beat_cnt_d;
            tmo_q         <= tmo_d;
            mosi_q        <= mosi_d;
            mosi_valid_q  <= mosi_valid_d;
            oe_q          <= oe_d;
            ie_q          <= ie_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.cmd_ready       = (state_q == S_IDLE);
    assign bus.wdata_ready     = (state_q == S_WR_DATA);
    assign bus.hzzm_mosi       = mosi_q;
    assign bus.hzzm_mosi_valid = mosi_valid_q;
    assign bus.hzzm_mosi_oe    = oe_q;
    assign bus.hzzm_miso_ie    = ie_q;
    assign bus.rdata           = rdata_q;
    assign bus.rdata_valid     = rdata_valid_q;
    assign bus.cmd_done        = done_q;
    assign bus.cmd_err         = err_q;
    assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_hzz_master_if.sv
// Directed bench for hzz_master_if with a behavioural DDR-side responder and wire scoreboards.
`timescale 1ns/1ps

module tb_hzz_master_if;
    localparam int W   = 64;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;

    hzz_master_if_if #(.W(W)) bus ();

    hzz_master_if #(.HZZ_T2D_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int adj_cnt  = 0;
    int done_cnt = 0;
    int rd_cnt   = 0;
    int hdr_cyc  = 0;
    int done_cyc = 0;
    logic prev_mv = 1'b0;
    bit   resp_silent = 1'b0;

    logic [W-1:0] exp_q[$];     // expected words on hzzm_mosi
    logic [W-1:0] rd_exp_q[$];  // expected words on rdata
    logic [W-1:0] wq[$];        // write beats to offer
    logic [W-1:0] mem[longint];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] hdr(input bit wr, input logic [53:0] a, input logic [7:0] l);
        logic [W-1:0] h;
        h           = '0;
        h[W-1]      = wr;
        h[W-2]      = ~wr;
        h[W-3 -: 8] = l;
        h[53:0]     = a;
        return h;
    endfunction

    // Wire monitor: scoreboards hzzm_mosi and rdata, records header/done cycles.
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (rst) begin
            prev_mv = 1'b0;
        end else begin
            if (bus.hzzm_mosi_valid) begin
                if (prev_mv) adj_cnt++;
                chk("mosi_pending", W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e[W-1:W-2] != 2'b00) hdr_cyc = cyc;
                    chk("mosi_word", bus.hzzm_mosi, e);
                end
            end
            prev_mv = bus.hzzm_mosi_valid;
            if (bus.rdata_valid) begin
                rd_cnt++;
                chk("rdata_pending", W'(rd_exp_q.size() != 0), 1);
                if (rd_exp_q.size() != 0) chk("rdata_word", bus.rdata, rd_exp_q.pop_front());
            end
            if (bus.cmd_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Responder: stores write beats, answers 2 cycles after the last beat, streams reads back.
    int         r_state = 0;
    int         r_idx   = 0;
    int         r_wait  = 0;
    logic [7:0] r_len   = '0;
    logic [53:0] r_addr = '0;

    initial begin
        bus.hzzm_miso       = '0;
        bus.hzzm_miso_valid = 1'b0;
        forever begin
            @(negedge clk);
            bus.hzzm_miso_valid = 1'b0;
            if (rst) begin
                r_state = 0;
            end else begin
                case (r_state)
                    0: if (bus.hzzm_mosi_valid) begin
                        r_len  = bus.hzzm_mosi[W-3 -: 8];
                        r_addr = bus.hzzm_mosi[53:0];
                        r_idx  = 0;
                        if (bus.hzzm_mosi[W-1]) r_state = 1;
                        else if (!resp_silent) r_state = 2;
                    end
                    1: if (bus.hzzm_mosi_valid) begin
                        mem[longint'(r_addr) + r_idx] = bus.hzzm_mosi;
                        if (r_idx == int'(r_len)) begin
                            r_state = 3;
                            r_wait  = 2;
                        end
                        r_idx++;
                    end
                    2: begin
                        bus.hzzm_miso       = mem[longint'(r_addr) + r_idx];
                        bus.hzzm_miso_valid = 1'b1;
                        if (r_idx == int'(r_len)) r_state = 0;
                        r_idx++;
                    end
                    3: begin
                        r_wait--;
                        if (r_wait == 0) begin
                            bus.hzzm_miso_valid = 1'b1;
                            r_state = 0;
                        end
                    end
                    default: r_state = 0;
                endcase
            end
        end
    end

    task automatic send_cmd(input bit wr, input logic [53:0] addr, input logic [7:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        for (int i = 0; i < 64 && !bus.cmd_ready; i++) tick();
        chk("cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_beats(input bit gap);
        int j = 0;
        int guard = 0;
        while (j < wq.size() && guard < 2000) begin
            bus.wdata_valid = 1'b1;
            bus.wdata       = wq[j];
            if (bus.wdata_ready) begin
                j++;
                tick();
                if (gap) begin
                    bus.wdata_valid = 1'b0;
                    tick();
                end
            end else begin
                tick();
            end
            guard++;
        end
        bus.wdata_valid = 1'b0;
        chk("wbeats_accepted", j, wq.size());
    endtask

    task automatic wait_done(input string tag, input bit exp_err, input int max, output int waited);
        int n = 0;
        while (!bus.cmd_done && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, bus.cmd_done, 1);
        chk({tag, "_err"}, bus.cmd_err, exp_err);
        waited = n;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mosi"}, bus.hzzm_mosi, 0);
        chk({tag, "_mosi_valid"}, bus.hzzm_mosi_valid, 0);
        chk({tag, "_oe"}, bus.hzzm_mosi_oe, 1);
        chk({tag, "_ie"}, bus.hzzm_miso_ie, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_rdata_valid"}, bus.rdata_valid, 0);
        chk({tag, "_done"}, bus.cmd_done, 0);
        chk({tag, "_err"}, bus.cmd_err, 0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w, d0, r0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // 1a: write 4 beats back-to-back
        adj_cnt = 0; d0 = done_cnt;
        wq = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
        exp_q.push_back(64'h80C0_0000_0000_0010);
        foreach (wq[i]) exp_q.push_back(wq[i]);
        send_cmd(1'b1, 54'h10, 8'd3);
        write_beats(1'b0);
        wait_done("t1w", 1'b0, 50, w);
        chk("t1w_latency", done_cyc - hdr_cyc, 8);
        chk("t1w_rv_at_done", bus.rdata_valid, 0);
        tick();
        chk("t1w_adjacent", adj_cnt, 3);
        chk("t1w_mosi_left", exp_q.size(), 0);
        chk("t1w_done_count", done_cnt - d0, 1);

        // 1b: read back
        d0 = done_cnt;
        exp_q.push_back(64'h40C0_0000_0000_0010);
        rd_exp_q = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
        send_cmd(1'b0, 54'h10, 8'd3);
        wait_done("t1r", 1'b0, 50, w);
        chk("t1r_rv_at_done", bus.rdata_valid, 1);
        chk("t1r_latency", done_cyc - hdr_cyc, 5);
        chk("t1r_oe_at_done", bus.hzzm_mosi_oe, 1);
        tick();
        chk("t1r_rd_left", rd_exp_q.size(), 0);
        chk("t1r_done_count", done_cnt - d0, 1);

        // 2: write with gaps, then read back
        adj_cnt = 0;
        wq = {64'hB0, 64'hB1, 64'hB2, 64'hB3, 64'hB4, 64'hB5, 64'hB6, 64'hB7};
        exp_q.push_back(hdr(1'b1, 54'h20, 8'd7));
        foreach (wq[i]) exp_q.push_back(wq[i]);
        send_cmd(1'b1, 54'h20, 8'd7);
        write_beats(1'b1);
        wait_done("t2w", 1'b0, 50, w);
        tick();
        chk("t2w_adjacent", adj_cnt, 0);
        chk("t2w_mosi_left", exp_q.size(), 0);
        exp_q.push_back(hdr(1'b0, 54'h20, 8'd7));
        foreach (wq[i]) rd_exp_q.push_back(wq[i]);
        send_cmd(1'b0, 54'h20, 8'd7);
        wait_done("t2r", 1'b0, 50, w);
        tick();
        chk("t2r_rd_left", rd_exp_q.size(), 0);

        // 3: illegal commands (misaligned address, bad length)
        d0 = done_cnt;
        send_cmd(1'b1, 54'h11, 8'd3);
        wait_done("t3a", 1'b1, 5, w);
        chk("t3a_latency", w, 0);
        chk("t3a_ready_at_done", bus.cmd_ready, 1);
        send_cmd(1'b0, 54'h10, 8'd4);
        wait_done("t3b", 1'b1, 5, w);
        chk("t3b_latency", w, 0);
        repeat (3) tick();
        chk("t3_done_count", done_cnt - d0, 2);

        // 4: silent responder, read times out
        resp_silent = 1'b1;
        exp_q.push_back(hdr(1'b0, 54'h40, 8'd3));
        send_cmd(1'b0, 54'h40, 8'd3);
        tick();
        chk("t4_oe_in_read", bus.hzzm_mosi_oe, 0);
        chk("t4_ie_in_read", bus.hzzm_miso_ie, 1);
        wait_done("t4", 1'b1, 40, w);
        chk("t4_latency", done_cyc - hdr_cyc, TMO + 1);
        chk("t4_oe_after", bus.hzzm_mosi_oe, 1);
        chk("t4_ie_after", bus.hzzm_miso_ie, 0);
        resp_silent = 1'b0;
        tick();

        // 5: reset after 2 of 4 read beats, then a clean read
        d0 = done_cnt; r0 = rd_cnt;
        exp_q.push_back(hdr(1'b0, 54'h10, 8'd3));
        rd_exp_q = {64'hA0, 64'hA1};
        send_cmd(1'b0, 54'h10, 8'd3);
        for (int i = 0; i < 50 && (rd_cnt - r0) < 2; i++) tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("t5_rst");
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_rd_count", rd_cnt - r0, 2);
        chk("t5_no_done", done_cnt - d0, 0);
        exp_q.push_back(hdr(1'b0, 54'h10, 8'd3));
        rd_exp_q = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
        send_cmd(1'b0, 54'h10, 8'd3);
        wait_done("t5r", 1'b0, 50, w);
        tick();
        chk("t5r_rd_left", rd_exp_q.size(), 0);

        // 6: maximum burst, 256 beats each way
        adj_cnt = 0; d0 = done_cnt;
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back({32'h1234_0000 + 32'(i), 32'hABCD_0000 + 32'(i)});
        exp_q.push_back(hdr(1'b1, 54'h100, 8'd255));
        foreach (wq[i]) exp_q.push_back(wq[i]);
        send_cmd(1'b1, 54'h100, 8'd255);
        write_beats(1'b0);
        wait_done("t6w", 1'b0, 50, w);
        chk("t6w_latency", done_cyc - hdr_cyc, 260);
        tick();
        chk("t6w_adjacent", adj_cnt, 255);
        chk("t6w_mosi_left", exp_q.size(), 0);
        r0 = rd_cnt;
        exp_q.push_back(hdr(1'b0, 54'h100, 8'd255));
        foreach (wq[i]) rd_exp_q.push_back(wq[i]);
        send_cmd(1'b0, 54'h100, 8'd255);
        wait_done("t6r", 1'b0, 300, w);
        chk("t6r_latency", done_cyc - hdr_cyc, 257);
        chk("t6r_beats_at_done", rd_cnt - r0, 256);
        repeat (3) tick();
        chk("t6r_rd_left", rd_exp_q.size(), 0);
        chk("t6_done_count", done_cnt - d0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hzz_master_if.md
# hzz_master_if

Initiator end of the HZZ host-to-DDR link: it accepts single-burst read/write commands from the accelerator's DMA engine and drives the HZZ header and data beats towards the DDR-side responder. It collects read beats or the write response and reports completion. It sits between the DLA DMA and the HZZ pad/tri-state logic and pairs directly with `dummy_ddrif` in simulation.

## Interface
- `HZZ_T2D_WIDTH`, from `PKG_dla_config` (64 or 256): HZZ data/header width W.
- `TIMEOUT_CYCLES`, default 1024: maximum idle cycles allowed while waiting for responder traffic.
- `clk` in 1: single clock.
- `rst` in 1: **reset is synchronous and active-high.**
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accept, high only in IDLE.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 54: beat address; bits [1:0] must be 0.
- `cmd_len` in 8: beats−1; bits [1:0] must be 2'b11.
- `wdata_valid` in 1: write beat available.
- `wdata_ready` out 1: write beat accept.
- `wdata` in W: write beat.
- `rdata_valid` out 1: read beat strobe. There is no backpressure.
- `rdata` out W: read beat.
- `cmd_done` out 1: 1-cycle completion pulse.
- `cmd_err` out 1: qualifies `cmd_done`; 1 = rejected or timed out.
- `hzzm_mosi` out W: header or write data towards the responder.
- `hzzm_mosi_valid` out 1: `hzzm_mosi` qualifier.
- `hzzm_mosi_oe` out 1: tri-state output enable for `hzzm_mosi`.
- `hzzm_miso_ie` out 1: tri-state input enable for `hzzm_miso`.
- `hzzm_miso` in W: read data from the responder.
- `hzzm_miso_valid` in 1: read beat or write-response strobe.

## Operation
- **Header word:**
  - bit W−1 = write flag.
  - bit W−2 = read flag; exactly one of the two flags is set.
  - bits [W−3 -: 8] = `cmd_len`.
  - bits [53:0] = `cmd_addr`.
  - All other bits are 0.
- **States:** IDLE, HDR, WR_DATA, WR_RESP, RD_DATA.
- **IDLE:**
  - `cmd_ready`=1.
  - On `cmd_valid` with a legal command, latch addr/len/dir, load the 8-bit beat counter with `cmd_len`, and go to HDR.
  - On an illegal command (`addr[1:0]`≠0 or `len[1:0]`≠11), consume it and stay in IDLE. Next cycle pulse `cmd_done`=1 with `cmd_err`=1. Nothing is driven on HZZ.
- **HDR:**
  - Drive the header for exactly one cycle with `hzzm_mosi_valid`=1.
  - Then go to WR_DATA (write) or RD_DATA (read).
- **WR_DATA:**
  - `wdata_ready`=1, decoded combinationally from the state.
  - Each accepted beat appears on `hzzm_mosi` with `hzzm_mosi_valid`=1 in the next cycle. In cycles with no accepted beat, `hzzm_mosi_valid`=0.
  - The counter decrements per accepted beat.
  - When the beat is accepted while the counter is 0, go to WR_RESP. That last beat is driven during the first WR_RESP cycle.
  - No timeout applies in WR_DATA.
- **WR_RESP:**
  - Wait for `hzzm_miso_valid`.
  - When it arrives: `cmd_done`=1, `cmd_err`=0 next cycle, and go to IDLE.
- **RD_DATA:**
  - Each `hzzm_miso_valid` produces `rdata`=`hzzm_miso` and `rdata_valid`=1 one cycle later. The counter decrements per beat.
  - On the beat received while the counter is 0: `cmd_done`=1, `cmd_err`=0, asserted in the same cycle as the final `rdata_valid`; then go to IDLE.
- **Timeout:**
  - Applies in WR_RESP and RD_DATA. The counter clears on entry and on each `hzzm_miso_valid`.
  - On reaching `TIMEOUT_CYCLES`: `cmd_done`=1, `cmd_err`=1, go to IDLE. Beats already delivered stand.
- **Spurious strobes:** `hzzm_miso_valid` in IDLE, HDR or WR_DATA is ignored.
- **Tri-state:**
  - `hzzm_mosi_oe`=0 only in RD_DATA; `hzzm_miso_ie`=1 only in WR_RESP and RD_DATA.
  - Both are registered and updated on the same edge as the state.

## Timing
- **Reset values:**
  - State = IDLE.
  - `hzzm_mosi`=0, `hzzm_mosi_valid`=0, `hzzm_mosi_oe`=1, `hzzm_miso_ie`=0.
  - `rdata`=0, `rdata_valid`=0, `cmd_done`=0, `cmd_err`=0.
  - Counters = 0.
- **Reset mid-operation:** abandons the burst with no `cmd_done`. The responder shares `rst` and returns to its idle state too.
- **Header latency:** the header is on the wire in the cycle after command acceptance.
- **Read latency:** `rdata` lags `hzzm_miso` by 1 cycle. Responder latency is arbitrary, within the timeout.
- **Back-to-back commands:** the minimum gap from `cmd_done` to the next header is 1 cycle. `cmd_ready` is high in the `cmd_done` cycle.
- **Beat count:** `cmd_len`+1 beats, i.e. 4..256.
  - Counter compare is ==0; decrement is modulo 8 bits and never wraps below 0 within a burst.
- **Write response:** expected 2 cycles after the last data beat on the wire, per the responder.

## Test plan
1. **Write, then read back (loopback with `dummy_ddrif`).**
   - Write: addr 0x10, len 3, wdata 0xA0..0xA3 back-to-back → header with write flag, len 3, addr 0x10; 4 consecutive data beats; `cmd_done`=1, `cmd_err`=0.
   - Read: same addr/len → header with read flag; `rdata` 0xA0,0xA1,0xA2,0xA3 in order; `cmd_done` on the 4th beat.
2. **Write with gaps.** addr 0x20, len 7, `wdata_valid` toggling every other cycle → `hzzm_mosi_valid` shows 8 isolated beats; readback returns identical data.
3. **Illegal commands.** addr 0x11 → no `hzzm_mosi_valid`; `cmd_done`=1, `cmd_err`=1 one cycle after accept. len 4 → same response.
4. **Timeout.** Responder silent, `TIMEOUT_CYCLES`=16, read of len 3 → `cmd_done`=1, `cmd_err`=1 exactly 16 cycles after entering RD_DATA; `hzzm_mosi_oe` returns to 1.
5. **Reset mid-read.** Assert `rst` after 2 of 4 read beats → all outputs at reset values next cycle; a following read of addr 0x10 completes correctly.
6. **Maximum burst.** len 255 write then read → 256 beats each, counters end at 0, with no early or late `cmd_done`.
